// File: rtl/trace_pkg.sv
// Shared widths and bit offsets of the packed write-back trace record.
// Record width grows by the timestamp field when WB_TRACE_TIMESTAMP_EN is defined.
package trace_pkg;

  localparam int unsigned TRACE_PC_W  = 32;
  localparam int unsigned TRACE_REG_W = 5;
  localparam int unsigned TRACE_VAL_W = 32;
  localparam int unsigned TRACE_TS_W  = 32;

  // Layout, LSB first: value, reg, ena, pc, [ts]
  localparam int unsigned TRACE_VAL_LSB = 0;
  localparam int unsigned TRACE_REG_LSB = TRACE_VAL_LSB + TRACE_VAL_W;
  localparam int unsigned TRACE_ENA_BIT = TRACE_REG_LSB + TRACE_REG_W;
  localparam int unsigned TRACE_PC_LSB  = TRACE_ENA_BIT + 1;
  localparam int unsigned TRACE_TS_LSB  = TRACE_PC_LSB + TRACE_PC_W;

`ifdef WB_TRACE_TIMESTAMP_EN
  localparam int unsigned TRACE_REC_W = TRACE_TS_LSB + TRACE_TS_W;
`else
  localparam int unsigned TRACE_REC_W = TRACE_TS_LSB;
`endif

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous first-word-fall-through FIFO; rdata reads 0 while empty.
// A push while full is accepted only if a pop happens in the same cycle.
module trace_fifo #(
  parameter int unsigned WIDTH = 70,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_pop  = pop & ~empty & ~clr;
  assign do_push = push & (~full | do_pop) & ~clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/wb_trace_capture.sv
// Packs retired write-back instructions into trace records, buffers them and counts drops.
// Optional WB_TRACE_TIMESTAMP_EN adds a free-running cycle stamp and the out_ts port.
module wb_trace_capture
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cap_en,
  input  logic                     flush,
  input  logic                     wb_have_inst,
  input  logic [TRACE_PC_W-1:0]    wb_pc,
  input  logic                     wb_ena,
  input  logic [TRACE_REG_W-1:0]   wb_reg,
  input  logic [TRACE_VAL_W-1:0]   wb_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TRACE_PC_W-1:0]    out_pc,
  output logic                     out_ena,
  output logic [TRACE_REG_W-1:0]   out_reg,
  output logic [TRACE_VAL_W-1:0]   out_value,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
`ifdef WB_TRACE_TIMESTAMP_EN
  output logic [TRACE_TS_W-1:0]    out_ts,
`endif
  output logic [DROP_W-1:0]        drop_cnt
);

  logic [TRACE_REC_W-1:0] rec_in, rec_out;
  logic                   push, pop, drop, fifo_full, fifo_empty;
  logic                   overflow_q, overflow_d;
  logic [DROP_W-1:0]      drop_cnt_q, drop_cnt_d;

  assign push = cap_en & wb_have_inst & ~flush;
  assign pop  = out_valid & out_ready;
  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign drop = push & fifo_full & ~pop;

`ifdef WB_TRACE_TIMESTAMP_EN
  logic [TRACE_TS_W-1:0] ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + TRACE_TS_W'(1);
  end
`endif

  always_comb begin
    rec_in = '0;
    rec_in[TRACE_PC_LSB +: TRACE_PC_W] = wb_pc;
    rec_in[TRACE_ENA_BIT]              = wb_ena;
    if (wb_ena) begin
      rec_in[TRACE_REG_LSB +: TRACE_REG_W] = wb_reg;
      rec_in[TRACE_VAL_LSB +: TRACE_VAL_W] = wb_value;
    end
`ifdef WB_TRACE_TIMESTAMP_EN
    rec_in[TRACE_TS_LSB +: TRACE_TS_W] = ts_q;
`endif
  end

  trace_fifo #(
    .WIDTH(TRACE_REC_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (flush),
    .push (push),
    .pop  (pop),
    .wdata(rec_in),
    .rdata(rec_out),
    .count(count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_valid = ~fifo_empty;
  assign out_pc    = rec_out[TRACE_PC_LSB +: TRACE_PC_W];
  assign out_ena   = rec_out[TRACE_ENA_BIT];
  assign out_reg   = rec_out[TRACE_REG_LSB +: TRACE_REG_W];
  assign out_value = rec_out[TRACE_VAL_LSB +: TRACE_VAL_W];
`ifdef WB_TRACE_TIMESTAMP_EN
  assign out_ts    = rec_out[TRACE_TS_LSB +: TRACE_TS_W];
`endif
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_capture.sv
// Bench for wb_trace_capture: queue-based record model checked every cycle plus directed
// literal expectations. Timestamp checks are compiled when WB_TRACE_TIMESTAMP_EN is defined.
module tb_wb_trace_capture;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DROP_W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cap_en = 1'b1;
  logic        flush = 1'b0;
  logic        wb_have_inst = 1'b0;
  logic [31:0] wb_pc = '0;
  logic        wb_ena = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_value = '0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_ena, overflow;
  logic [31:0] out_pc, out_value;
  logic [4:0]  out_reg;
  logic [4:0]  count;
  logic [15:0] drop_cnt;
`ifdef WB_TRACE_TIMESTAMP_EN
  logic [31:0] out_ts;
`endif

  wb_trace_capture #(
    .DEPTH (DEPTH),
    .DROP_W(DROP_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cap_en      (cap_en),
    .flush       (flush),
    .wb_have_inst(wb_have_inst),
    .wb_pc       (wb_pc),
    .wb_ena      (wb_ena),
    .wb_reg      (wb_reg),
    .wb_value    (wb_value),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_ena     (out_ena),
    .out_reg     (out_reg),
    .out_value   (out_value),
    .count       (count),
    .overflow    (overflow),
`ifdef WB_TRACE_TIMESTAMP_EN
    .out_ts      (out_ts),
`endif
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of sanitised records plus drop bookkeeping.
  typedef struct {
    logic [31:0] pc;
    logic        ena;
    logic [4:0]  rg;
    logic [31:0] val;
    logic [31:0] ts;
  } rec_t;

  rec_t        mq[$];
  logic        m_ovf = 1'b0;
  logic [15:0] m_drop = '0;
  logic [31:0] m_cyc = '0;

  always @(posedge clk or negedge rst_n) begin : model
    int   n;
    logic pp;
    rec_t r;
    if (!rst_n) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_drop = '0;
      m_cyc  = '0;
    end else begin
      if (flush) begin
        mq.delete();
        m_ovf  = 1'b0;
        m_drop = '0;
      end else begin
        n  = mq.size();
        pp = (n != 0) && out_ready;
        if (pp) r = mq.pop_front();
        if (cap_en && wb_have_inst) begin
          if (n == DEPTH && !pp) begin
            m_ovf = 1'b1;
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
          end else begin
            r.pc  = wb_pc;
            r.ena = wb_ena;
            r.rg  = wb_ena ? wb_reg : 5'd0;
            r.val = wb_ena ? wb_value : 32'd0;
            r.ts  = m_cyc;
            mq.push_back(r);
          end
        end
      end
      m_cyc = m_cyc + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", out_valid, mq.size() != 0);
      chk("count", count, mq.size());
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
      if (mq.size() != 0) begin
        chk("out_pc", out_pc, mq[0].pc);
        chk("out_ena", out_ena, mq[0].ena);
        chk("out_reg", out_reg, mq[0].rg);
        chk("out_value", out_value, mq[0].val);
`ifdef WB_TRACE_TIMESTAMP_EN
        chk("out_ts", out_ts, mq[0].ts);
`endif
      end else begin
        chk("empty_pc", out_pc, 0);
        chk("empty_value", out_value, 0);
      end
    end
  end

  // Apply inputs, let one rising edge sample them, return 1 time unit later.
  task automatic drive(input logic have, input logic [31:0] pc, input logic ena,
                       input logic [4:0] rg, input logic [31:0] val, input logic rdy,
                       input logic fl);
    wb_have_inst = have;
    wb_pc        = pc;
    wb_ena       = ena;
    wb_reg       = rg;
    wb_value     = val;
    out_ready    = rdy;
    flush        = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, rdy, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    rst_n = 1'b1;
    chk("rst_overflow", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_pc", out_pc, 0);

    // Basic capture and in-order drain
    drive(1'b1, 32'h0, 1'b1, 5'd5, 32'h11, 1'b0, 1'b0);
    drive(1'b1, 32'h4, 1'b1, 5'd5, 32'h22, 1'b0, 1'b0);
    drive(1'b1, 32'h8, 1'b1, 5'd5, 32'h33, 1'b0, 1'b0);
    chk("basic_count", count, 3);
    chk("basic_head_pc", out_pc, 32'h0);
    chk("basic_head_val", out_value, 32'h11);
    idle(1'b1);
    chk("drain1_pc", out_pc, 32'h4);
    idle(1'b1);
    chk("drain2_val", out_value, 32'h33);
    idle(1'b1);
    chk("drain_done", out_valid, 0);

    // Sanitise ena=0 records
    drive(1'b1, 32'h40, 1'b0, 5'd7, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("san_valid", out_valid, 1);
    chk("san_reg", out_reg, 0);
    chk("san_value", out_value, 0);
    chk("san_ena", out_ena, 0);
    idle(1'b1);

    // Overflow: 20 pushes into 16 entries
    for (int i = 0; i < 20; i++) drive(1'b1, 32'(4 * i), 1'b1, i[4:0], 32'(i), 1'b0, 1'b0);
    chk("ovf_count", count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_cnt, 4);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain_pc", out_pc, 32'(4 * i));
      idle(1'b1);
    end
    chk("ovf_empty", out_valid, 0);

    // Full with simultaneous push and pop: no drop
    for (int i = 0; i < 16; i++) drive(1'b1, 32'(4 * i), 1'b1, 5'd1, 32'(i), 1'b0, 1'b0);
    drive(1'b1, 32'h100, 1'b1, 5'd2, 32'h99, 1'b1, 1'b0);
    chk("fullpp_count", count, 16);
    chk("fullpp_drop", drop_cnt, 4);
    chk("fullpp_head", out_pc, 32'h4);
    for (int i = 0; i < 15; i++) idle(1'b1);
    chk("fullpp_last", out_pc, 32'h100);
    idle(1'b1);

    // Flush with 5 entries and drop_cnt=2, pushing in the same cycle
    drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("flush0_drop", drop_cnt, 0);
    for (int i = 0; i < 18; i++) drive(1'b1, 32'(4 * i), 1'b1, 5'd3, 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) idle(1'b1);
    chk("pre_flush_count", count, 5);
    chk("pre_flush_drop", drop_cnt, 2);
    drive(1'b1, 32'h200, 1'b1, 5'd4, 32'h55, 1'b1, 1'b1);
    chk("flush_count", count, 0);
    chk("flush_ovf", overflow, 0);
    chk("flush_drop", drop_cnt, 0);
    chk("flush_valid", out_valid, 0);
    idle(1'b0);
    chk("flush_nocap", count, 0);

    // cap_en=0: no pushes
    cap_en = 1'b0;
    drive(1'b1, 32'h300, 1'b1, 5'd6, 32'h66, 1'b0, 1'b0);
    chk("capen_count", count, 0);
    cap_en = 1'b1;

    // Asynchronous reset mid-drain
    for (int i = 0; i < 3; i++) drive(1'b1, 32'(8 * i), 1'b1, 5'd9, 32'(i), 1'b0, 1'b0);
    idle(1'b1);
    chk("mid_count", count, 2);
    idle(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_count", count, 0);
    chk("async_pc", out_pc, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef WB_TRACE_TIMESTAMP_EN
    for (int i = 0; i < 10; i++) idle(1'b0);
    drive(1'b1, 32'h10, 1'b1, 5'd1, 32'h1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    drive(1'b1, 32'h14, 1'b1, 5'd1, 32'h2, 1'b0, 1'b0);
    chk("ts_first", out_ts, 10);
    idle(1'b1);
    chk("ts_second", out_ts, 13);
    idle(1'b1);
    for (int i = 0; i < 4; i++) idle(1'b0);
    drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    drive(1'b1, 32'h18, 1'b1, 5'd1, 32'h3, 1'b0, 1'b0);
    chk("ts_after_flush", out_ts, 21);
    idle(1'b1);
`endif

    idle(1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
